// File: rtl/orun_status_pkg.sv
// Shared definitions for the overrun status scheduler: FSM states,
// status-word field positions and default sizing.
package orun_status_pkg;

    localparam int N_SRC_DEF  = 4;
    localparam int CNT_W_DEF  = 24;
    localparam int DWELL_DEF  = 16;

    localparam int IDX_HI     = 31;
    localparam int IDX_LO     = 30;
    localparam int STICKY_BIT = 29;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW     = 2'd1,
        CLEAR    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

endpackage

// File: rtl/orun_chan_counter.sv
// One overrun channel: saturating event counter with a sticky overflow flag.
// The synchronous clear takes priority over a coincident event.
module orun_chan_counter
    import orun_status_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sticky
);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            count  <= '0;
            sticky <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            sticky <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                sticky <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/orun_status_sched.sv
// Rotates per-source overrun counts onto a 32-bit status word and runs the
// software clear handshake.
//
//   state    | meaning
//   IDLE     | disabled or leaving reset; status word zero, rotation parked at 0
//   SHOW     | presenting source idx for DWELL cycles each, round-robin
//   CLEAR    | single cycle wiping all counters, flags and rotation
//   WAIT_REL | clr_ack high until software drops clr_req
module orun_status_sched
    import orun_status_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic             enable,
    input  logic [N_SRC-1:0] orun_in,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic [31:0]      user_data_in,
    output logic             status_valid
);

    localparam int DW_W = $clog2(DWELL);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       rst_sync;
    logic             clr_req_q;
    logic             clr_edge;
    logic             chan_clr;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_nxt;
    logic [CNT_W-1:0] cnt [N_SRC];
    logic [N_SRC-1:0] sticky;
    logic [CNT_W-1:0] cnt_sel;
    logic             sticky_sel;
    logic [31:0]      word_nxt;

    assign chan_clr = (state == CLEAR);
    assign clr_edge = clr_req & ~clr_req_q;

    for (genvar i = 0; i < N_SRC; i++) begin : g_chan
        orun_chan_counter #(.CNT_W(CNT_W)) u_chan (
            .user_clk   (user_clk),
            .user_rst_n (user_rst_n),
            .clr        (chan_clr),
            .inc        (orun_in[i] & enable),
            .count      (cnt[i]),
            .sticky     (sticky[i])
        );
    end

    // Edge history resets to 1 so a clr_req held through reset is not a new request.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            rst_sync  <= '0;
            clr_req_q <= 1'b1;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            clr_req_q <= clr_req;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr_edge) begin
            state_nxt = CLEAR;
        end else begin
            case (state)
                IDLE:     if (enable && rst_sync[1]) state_nxt = SHOW;
                SHOW:     if (!enable) state_nxt = IDLE;
                CLEAR:    state_nxt = WAIT_REL;
                WAIT_REL: if (!clr_req) state_nxt = enable ? SHOW : IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Rotation only advances while staying in SHOW; any other path parks it at 0.
    always_comb begin
        idx_nxt   = '0;
        dwell_nxt = '0;
        if (state == SHOW && state_nxt == SHOW) begin
            if (dwell == DW_W'(DWELL - 1)) begin
                idx_nxt = (idx == 2'(N_SRC - 1)) ? 2'd0 : idx + 2'd1;
            end else begin
                idx_nxt   = idx;
                dwell_nxt = dwell + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_sel    = '0;
        sticky_sel = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (idx_nxt == 2'(i)) begin
                cnt_sel    = cnt[i];
                sticky_sel = sticky[i];
            end
        end
        word_nxt                 = '0;
        word_nxt[IDX_HI:IDX_LO]  = idx_nxt;
        word_nxt[STICKY_BIT]     = sticky_sel;
        word_nxt[CNT_W-1:0]      = cnt_sel;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            dwell        <= '0;
            clr_ack      <= 1'b0;
            status_valid <= 1'b0;
            user_data_in <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            dwell        <= dwell_nxt;
            clr_ack      <= (state_nxt == WAIT_REL);
            status_valid <= (state_nxt == SHOW);
            user_data_in <= (state_nxt == SHOW) ? word_nxt : '0;
        end
    end

endmodule

// File: tb/tb_orun_status_sched.sv
// Directed bench for orun_status_sched: expected status words are queued as
// each cycle is driven and popped against the registered outputs.
module tb_orun_status_sched;

    logic        user_clk   = 1'b0;
    logic        user_rst_n = 1'b1;
    logic        enable     = 1'b0;
    logic [3:0]  orun_in    = 4'b0;
    logic        clr_req    = 1'b0;
    logic        clr_ack;
    logic        status_valid;
    logic [31:0] user_data_in;
    logic        sat_clr_ack;
    logic        sat_status_valid;
    logic [31:0] sat_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        valid;
        logic        ack;
    } exp_t;

    exp_t sb_q[$];

    logic [1:0]  ix;
    int          c;
    logic [31:0] exp_w;
    logic [3:0]  orun_v;

    always #5 user_clk = ~user_clk;

    orun_status_sched dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .enable       (enable),
        .orun_in      (orun_in),
        .clr_req      (clr_req),
        .clr_ack      (clr_ack),
        .user_data_in (user_data_in),
        .status_valid (status_valid)
    );

    orun_status_sched #(.CNT_W(4)) dut_sat (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .enable       (enable),
        .orun_in      (orun_in),
        .clr_req      (clr_req),
        .clr_ack      (sat_clr_ack),
        .user_data_in (sat_data),
        .status_valid (sat_status_valid)
    );

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check32({e.tag, "_data"},  user_data_in, e.data);
            check32({e.tag, "_valid"}, 32'(status_valid), 32'(e.valid));
            check32({e.tag, "_ack"},   32'(clr_ack), 32'(e.ack));
        end
    endtask

    task automatic step(input logic [3:0] orun, input logic en, input logic clr,
                        input logic [31:0] exp_data, input logic exp_valid,
                        input logic exp_ack, input string tag);
        exp_t e;
        orun_in = orun;
        enable  = en;
        clr_req = clr;
        e.tag   = tag;
        e.data  = exp_data;
        e.valid = exp_valid;
        e.ack   = exp_ack;
        sb_q.push_back(e);
        tick();
        pop_check();
    endtask

    initial begin
        #2 user_rst_n = 1'b0;
        #1;
        check32("rst_now_data",  user_data_in, 32'h0);
        check32("rst_now_valid", 32'(status_valid), 32'h0);
        check32("rst_now_ack",   32'(clr_ack), 32'h0);
        repeat (3) tick();
        user_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");

        // Plain rotation, then five events on source 2 while source 0 is shown.
        for (int j = 0; j <= 111; j++) begin
            ix     = 2'((j / 16) % 4);
            c      = (ix == 2'd2 && j >= 70) ? 5 : 0;
            orun_v = (j >= 65 && j <= 69) ? 4'b0100 : 4'b0000;
            exp_w  = {ix, 30'(c)};
            step(orun_v, 1'b1, 1'b0, exp_w, 1'b1, 1'b0, $sformatf("rot_%0d", j));
        end

        // Clear request rising together with events on every source.
        step(4'b1111, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, "clr_edge");
        step(4'b1111, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, "clr_cycle");
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, "wait_rel_a");
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, "wait_rel_b");
        step(4'b0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "clr_release");

        // All sources pulsed together for three cycles.
        for (int k = 1; k <= 64; k++) begin
            ix     = 2'((k / 16) % 4);
            c      = (k <= 1) ? 0 : ((k >= 4) ? 3 : k - 1);
            orun_v = (k <= 3) ? 4'b1111 : 4'b0000;
            exp_w  = {ix, 30'(c)};
            step(orun_v, 1'b1, 1'b0, exp_w, 1'b1, 1'b0, $sformatf("all3_%0d", k));
        end

        // Disabled: status parked, events ignored, counts retained.
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "disabled");
        for (int k = 0; k < 32; k++) begin
            ix    = 2'((k / 16) % 4);
            exp_w = {ix, 30'd3};
            step(4'b0000, 1'b1, 1'b0, exp_w, 1'b1, 1'b0, $sformatf("retain_%0d", k));
        end

        // Reset asserted while waiting for clr_req release.
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, "clr2_edge");
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, "clr2_cycle");
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, "clr2_wait");
        user_rst_n = 1'b0;
        #2;
        check32("rst_async_ack",   32'(clr_ack), 32'h0);
        check32("rst_async_data",  user_data_in, 32'h0);
        check32("rst_async_valid", 32'(status_valid), 32'h0);
        tick();
        tick();
        user_rst_n = 1'b1;
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, "sync_1");
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, "sync_2");
        step(4'b0000, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, "resume");

        // Seventeen events on source 1; the 4-bit instance saturates.
        for (int k = 1; k < 32; k++) begin
            ix     = 2'((k / 16) % 4);
            c      = (ix == 2'd1) ? ((k - 1 > 17) ? 17 : k - 1) : 0;
            orun_v = (k <= 17) ? 4'b0010 : 4'b0000;
            exp_w  = {ix, 30'(c)};
            step(orun_v, 1'b1, 1'b1, exp_w, 1'b1, 1'b0, $sformatf("sat_%0d", k));
            if (k >= 16) begin
                check32($sformatf("sat4_%0d", k), sat_data,
                        (k == 16) ? 32'h4000_000F : 32'h6000_000F);
            end
        end

        clr_req = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
